// File: rtl/stack_calc_pkg.sv
// Shared types and sizing helpers for the RPN stack calculator.
// The optional STACK_CALC_SAT_EN macro, consumed by the engine, selects saturating arithmetic.
package stack_calc_pkg;

  localparam int DEFAULT_DEPTH = 256;
  localparam int DEFAULT_WIDTH = 32;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH) + 1;

  // The extra bit lets "full" and "empty" be distinct counts without wrap.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_DUP  = 3'b001,
    OP_SWAP = 3'b010,
    OP_SUB  = 3'b011,
    OP_ADD  = 3'b100,
    OP_MUL  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

endpackage

// File: rtl/stack_calc_if.sv
// Command/response bundle of the stack calculator.
// cmd: transfer on a rising edge where cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no backpressure.
import stack_calc_pkg::*;

interface stack_calc_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
);
  localparam int PW = ptr_width(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             rsp_ovf;
  logic [PW-1:0]    depth;
  logic             empty;
  logic             full;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_ovf, depth, empty, full
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_ovf, depth, empty, full
  );

endinterface

// File: rtl/stack_calc_mul.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles.
// o_done flags the final iteration cycle, so o_product is complete on the following cycle.
module stack_calc_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CW'(WIDTH);
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == CW'(1));
  assign o_product = r_acc;

endmodule

// File: rtl/stack_calc_engine.sv
// RPN stack calculator core: LIFO register stack plus execute unit with iterative multiplier.
// Define STACK_CALC_SAT_EN for saturating results; otherwise results wrap modulo 2^WIDTH.
import stack_calc_pkg::*;

module stack_calc_engine #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  stack_calc_if.slave   bus,
  output state_e        o_state
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
`ifdef STACK_CALC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PW-1:0]      r_depth;
  state_e             r_state, w_state_nxt;
  op_e                r_op;
  logic [WIDTH-1:0]   r_data;
  logic               r_rsp_valid, r_rsp_err, r_rsp_ovf;
  logic [WIDTH-1:0]   r_rsp_data;

  logic               w_accept, w_has1, w_has2, w_full, w_mul_start;
  logic               w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [AW-1:0]      w_idx_t, w_idx_s, w_idx_n;
  logic [WIDTH-1:0]   w_t, w_s;
  logic [WIDTH:0]     w_sum, w_diff;
  logic               w_err, w_ovf;
  logic [WIDTH-1:0]   w_res;
  logic               w_we_a, w_we_b;
  logic [AW-1:0]      w_wa_a, w_wa_b;
  logic [WIDTH-1:0]   w_wd_a, w_wd_b;
  logic [PW-1:0]      w_depth_nxt;

  assign w_accept = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_has1   = (r_depth != '0);
  assign w_has2   = (r_depth >= PW'(2));
  assign w_full   = (r_depth == PW'(DEPTH));
  // Truncated indices are only dereferenced when the depth guards allow it.
  assign w_idx_t  = AW'(r_depth - PW'(1));
  assign w_idx_s  = AW'(r_depth - PW'(2));
  assign w_idx_n  = AW'(r_depth);
  assign w_t      = r_mem[w_idx_t];
  assign w_s      = r_mem[w_idx_s];
  assign w_sum    = {1'b0, w_s} + {1'b0, w_t};
  assign w_diff   = {1'b0, w_s} - {1'b0, w_t};
  assign w_mul_start = w_accept && (op_e'(bus.cmd_op) == OP_MUL) && w_has2;

  stack_calc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (w_s),
    .i_b       (w_t),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_mul_start ? ST_MUL : ST_EXEC;
      ST_EXEC: w_state_nxt = ST_IDLE;
      ST_MUL:  if (w_mul_done || !w_mul_busy) w_state_nxt = ST_EXEC;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_err = 1'b0;
    w_ovf = 1'b0;
    w_res = '0;
    w_we_a = 1'b0;
    w_wa_a = w_idx_t;
    w_wd_a = '0;
    w_we_b = 1'b0;
    w_wa_b = w_idx_s;
    w_wd_b = '0;
    w_depth_nxt = r_depth;
    case (r_op)
      OP_NOP:  w_res = w_has1 ? w_t : '0;
      OP_DUP: begin
        if (!w_has1 || w_full) w_err = 1'b1;
        else begin
          w_res = w_t; w_we_a = 1'b1; w_wa_a = w_idx_n; w_wd_a = w_t;
          w_depth_nxt = r_depth + PW'(1);
        end
      end
      OP_SWAP: begin
        if (!w_has2) w_err = 1'b1;
        else begin
          w_res = w_s;
          w_we_a = 1'b1; w_wd_a = w_s;
          w_we_b = 1'b1; w_wd_b = w_t;
        end
      end
      OP_SUB, OP_ADD, OP_MUL: begin
        if (!w_has2) w_err = 1'b1;
        else begin
          if (r_op == OP_SUB) begin
            w_ovf = w_diff[WIDTH];
            w_res = (SAT_EN && w_ovf) ? '0 : w_diff[WIDTH-1:0];
          end else if (r_op == OP_ADD) begin
            w_ovf = w_sum[WIDTH];
            w_res = (SAT_EN && w_ovf) ? '1 : w_sum[WIDTH-1:0];
          end else begin
            w_ovf = |w_prod[2*WIDTH-1:WIDTH];
            w_res = (SAT_EN && w_ovf) ? '1 : w_prod[WIDTH-1:0];
          end
          // Result replaces S, which becomes the new top.
          w_we_b = 1'b1; w_wd_b = w_res;
          w_depth_nxt = r_depth - PW'(1);
        end
      end
      OP_PUSH: begin
        if (w_full) w_err = 1'b1;
        else begin
          w_res = r_data; w_we_a = 1'b1; w_wa_a = w_idx_n; w_wd_a = r_data;
          w_depth_nxt = r_depth + PW'(1);
        end
      end
      OP_POP: begin
        if (!w_has1) w_err = 1'b1;
        else begin
          w_res = w_t;
          w_depth_nxt = r_depth - PW'(1);
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_depth     <= '0;
      r_op        <= OP_NOP;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= (r_state == ST_EXEC);
      if (w_accept) begin
        r_op   <= op_e'(bus.cmd_op);
        r_data <= bus.cmd_data;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= w_res;
        r_rsp_err  <= w_err;
        r_rsp_ovf  <= w_ovf;
        r_depth    <= w_depth_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_EXEC) begin
      if (w_we_a) r_mem[w_wa_a] <= w_wd_a;
      if (w_we_b) r_mem[w_wa_b] <= w_wd_b;
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_ovf   = r_rsp_ovf;
  assign bus.depth     = r_depth;
  assign bus.empty     = !w_has1;
  assign bus.full      = w_full;
  assign o_state       = r_state;

endmodule

// File: tb/tb_stack_calc_engine.sv
// Directed bench for stack_calc_engine at WIDTH=8, DEPTH=4 with hand-computed expectations.
// Build with STACK_CALC_SAT_EN defined to check the saturating variant.
import stack_calc_pkg::*;

module tb_stack_calc_engine;
  localparam int W = 8;
  localparam int D = 4;

  localparam logic [2:0] NOP = 3'b000, DUP = 3'b001, SWAP = 3'b010, SUB = 3'b011,
                         ADD = 3'b100, MUL = 3'b101, PUSH = 3'b110, POP = 3'b111;
`ifdef STACK_CALC_SAT_EN
  localparam logic [W-1:0] EXP_ADD = 8'd255, EXP_SUB = 8'd0, EXP_MUL = 8'd255;
`else
  localparam logic [W-1:0] EXP_ADD = 8'd44, EXP_SUB = 8'd254, EXP_MUL = 8'd4;
`endif

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  stack_calc_if #(.WIDTH(W), .DEPTH(D)) bus ();

  stack_calc_engine #(.DEPTH(D), .WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rd;
  logic         er, ov, rs;
  int           lat;

  // Issue one command; lat = rising edges from accept to rsp_valid, rs = cmd_ready seen high meanwhile.
  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] data);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    rs  = 1'b0;
    while (lat < 50) begin
      @(posedge clk);
      #1 lat++;
      if (bus.rsp_valid) break;
      if (bus.cmd_ready) rs = 1'b1;
    end
    rd = bus.rsp_data;
    er = bus.rsp_err;
    ov = bus.rsp_ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = NOP;
    bus.cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'd0) begin errors++; $display("FAIL reset_rsp_data got %0d want 0", bus.rsp_data); end
    checks++; if ({bus.rsp_err, bus.rsp_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.rsp_err, bus.rsp_ovf}); end
    checks++; if (bus.depth !== 3'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", bus.depth); end
    checks++; if ({bus.empty, bus.full} !== 2'b10) begin errors++; $display("FAIL reset_empty_full got %b want 10", {bus.empty, bus.full}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    do_cmd(PUSH, 8'd200);
    do_cmd(PUSH, 8'd100);
    do_cmd(ADD, 8'd0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    checks++; if (rd !== EXP_ADD) begin errors++; $display("FAIL add_data got %0d want %0d", rd, EXP_ADD); end
    checks++; if ({er, ov} !== 2'b01) begin errors++; $display("FAIL add_flags got %b want 01", {er, ov}); end
    checks++; if (bus.depth !== 3'd1) begin errors++; $display("FAIL add_depth got %0d want 1", bus.depth); end
    do_cmd(POP, 8'd0);
    checks++; if (rd !== EXP_ADD || !bus.empty) begin errors++; $display("FAIL add_pop got %0d/%b want %0d/1", rd, bus.empty, EXP_ADD); end
  endtask

  task automatic test_sub();
    do_cmd(PUSH, 8'd3);
    do_cmd(PUSH, 8'd5);
    do_cmd(SUB, 8'd0);
    checks++; if (rd !== EXP_SUB) begin errors++; $display("FAIL sub_data got %0d want %0d", rd, EXP_SUB); end
    checks++; if ({er, ov} !== 2'b01) begin errors++; $display("FAIL sub_flags got %b want 01", {er, ov}); end
    do_cmd(POP, 8'd0);
    checks++; if (rd !== EXP_SUB) begin errors++; $display("FAIL sub_pop_data got %0d want %0d", rd, EXP_SUB); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL sub_pop_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_mul();
    do_cmd(PUSH, 8'd20);
    do_cmd(PUSH, 8'd13);
    do_cmd(MUL, 8'd0);
    checks++; if (lat !== 9) begin errors++; $display("FAIL mul_latency got %0d want 9", lat); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul_ready_low got %b want 0", rs); end
    checks++; if (rd !== EXP_MUL) begin errors++; $display("FAIL mul_data got %0d want %0d", rd, EXP_MUL); end
    checks++; if ({er, ov} !== 2'b01) begin errors++; $display("FAIL mul_flags got %b want 01", {er, ov}); end
    checks++; if (bus.depth !== 3'd1) begin errors++; $display("FAIL mul_depth got %0d want 1", bus.depth); end
    do_cmd(PUSH, 8'd7);
    do_cmd(PUSH, 8'd6);
    do_cmd(MUL, 8'd0);
    checks++; if (rd !== 8'd42 || ov !== 1'b0) begin errors++; $display("FAIL mul_small got %0d/%b want 42/0", rd, ov); end
    do_cmd(POP, 8'd0);
    do_cmd(POP, 8'd0);
    checks++; if (rd !== EXP_MUL || !bus.empty) begin errors++; $display("FAIL mul_pop got %0d/%b want %0d/1", rd, bus.empty, EXP_MUL); end
  endtask

  task automatic test_full_empty();
    do_cmd(PUSH, 8'd1);
    do_cmd(PUSH, 8'd2);
    do_cmd(PUSH, 8'd3);
    do_cmd(PUSH, 8'd4);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", bus.full); end
    do_cmd(PUSH, 8'd9);
    checks++; if ({er, ov, rd} !== {2'b10, 8'd0}) begin errors++; $display("FAIL push_full got err=%b ovf=%b data=%0d want 1 0 0", er, ov, rd); end
    checks++; if (bus.depth !== 3'd4 || bus.full !== 1'b1) begin errors++; $display("FAIL push_full_depth got %0d want 4", bus.depth); end
    do_cmd(NOP, 8'd0);
    checks++; if (rd !== 8'd4 || er !== 1'b0) begin errors++; $display("FAIL full_top got %0d want 4", rd); end
    do_cmd(DUP, 8'd0);
    checks++; if (er !== 1'b1 || bus.depth !== 3'd4) begin errors++; $display("FAIL dup_full got err=%b depth=%0d want 1 4", er, bus.depth); end
    do_cmd(POP, 8'd0);
    do_cmd(POP, 8'd0);
    do_cmd(POP, 8'd0);
    do_cmd(POP, 8'd0);
    checks++; if (rd !== 8'd1 || bus.empty !== 1'b1) begin errors++; $display("FAIL drain got %0d/%b want 1/1", rd, bus.empty); end
    do_cmd(POP, 8'd0);
    checks++; if ({er, ov, rd} !== {2'b10, 8'd0}) begin errors++; $display("FAIL pop_empty got err=%b ovf=%b data=%0d want 1 0 0", er, ov, rd); end
    do_cmd(NOP, 8'd0);
    checks++; if (rd !== 8'd0 || er !== 1'b0) begin errors++; $display("FAIL nop_empty got %0d/%b want 0/0", rd, er); end
  endtask

  task automatic test_swap_dup();
    do_cmd(PUSH, 8'd1);
    do_cmd(PUSH, 8'd2);
    do_cmd(SWAP, 8'd0);
    checks++; if (rd !== 8'd1 || er !== 1'b0) begin errors++; $display("FAIL swap_data got %0d want 1", rd); end
    do_cmd(DUP, 8'd0);
    checks++; if (rd !== 8'd1 || er !== 1'b0) begin errors++; $display("FAIL dup_data got %0d want 1", rd); end
    checks++; if (bus.depth !== 3'd3) begin errors++; $display("FAIL dup_depth got %0d want 3", bus.depth); end
    do_cmd(POP, 8'd0);
    do_cmd(POP, 8'd0);
    do_cmd(POP, 8'd0);
    checks++; if (rd !== 8'd2) begin errors++; $display("FAIL swap_bottom got %0d want 2", rd); end
    do_cmd(SWAP, 8'd0);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL swap_empty got %b want 1", er); end
    do_cmd(PUSH, 8'd7);
    do_cmd(ADD, 8'd0);
    checks++; if ({er, ov, rd} !== {2'b10, 8'd0} || bus.depth !== 3'd1) begin errors++; $display("FAIL add_short got err=%b data=%0d depth=%0d want 1 0 1", er, rd, bus.depth); end
    do_cmd(MUL, 8'd0);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL mul_short got err=%b lat=%0d want 1 1", er, lat); end
    do_cmd(POP, 8'd0);
    checks++; if (rd !== 8'd7 || !bus.empty) begin errors++; $display("FAIL short_pop got %0d want 7", rd); end
  endtask

  task automatic test_back_to_back();
    do_cmd(PUSH, 8'd10);
    do_cmd(PUSH, 8'd3);
    do_cmd(SUB, 8'd0);
    checks++; if (rd !== 8'd7 || ov !== 1'b0) begin errors++; $display("FAIL sub_plain got %0d/%b want 7/0", rd, ov); end
    do_cmd(PUSH, 8'd248);
    do_cmd(ADD, 8'd0);
    checks++; if (rd !== 8'd255 || ov !== 1'b0) begin errors++; $display("FAIL add_plain got %0d/%b want 255/0", rd, ov); end
    do_cmd(POP, 8'd0);
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    seen = 1'b0;
    do_cmd(PUSH, 8'd20);
    do_cmd(PUSH, 8'd13);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = MUL;
    bus.cmd_data  = '0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (bus.rsp_valid) seen = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1 if (bus.rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rsp got %b want 0", seen); end
    checks++; if (bus.depth !== 3'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL abort_depth got %0d want 0", bus.depth); end
    checks++; if (bus.cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_ready got %b want 1", bus.cmd_ready); end
    do_cmd(PUSH, 8'd5);
    checks++; if (rd !== 8'd5 || bus.depth !== 3'd1) begin errors++; $display("FAIL abort_recover got %0d/%0d want 5/1", rd, bus.depth); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_full_empty();
    test_swap_dup();
    test_back_to_back();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_calc_engine.md
# stack_calc_engine

Parametrised RPN stack calculator: a LIFO operand store plus a unified execute unit. Arithmetic ops pop their operands and push the result, instead of only peeking at them. Commands enter through a valid/ready handshake. Each accepted command returns exactly one registered response with error and overflow flags. Sits behind the command decoder as the datapath core of the calculator subsystem.

## Interface
- DEPTH, 256, stack entries (power of two, ≥2)
- WIDTH, 32, operand/result width in bits (≥4)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command; high only in IDLE
- cmd_op  in  3  opcode (see Operation)
- cmd_data  in  WIDTH  PUSH operand; ignored for other ops
- rsp_valid  out  1  one-cycle pulse per completed command
- rsp_data  out  WIDTH  response value; held until next response
- rsp_err  out  1  command rejected, stack unchanged; qualified by rsp_valid
- rsp_ovf  out  1  arithmetic overflow/borrow; qualified by rsp_valid
- depth  out  $clog2(DEPTH)+1  current entry count
- empty  out  1  depth==0
- full  out  1  depth==DEPTH

## Operation
- Naming: T = top entry, S = second entry. All arithmetic is unsigned.
- 000 NOP: no change. rsp_data = T, or 0 if empty.
- 001 DUP: push T. Error if depth<1 or full.
- 010 SWAP: exchange T and S. Error if depth<2. rsp_data = new T.
- 011 SUB: pop 2, push S−T. rsp_ovf = borrow (S<T).
- 100 ADD: pop 2, push S+T. rsp_ovf = carry out of WIDTH.
- 101 MUL: pop 2, push low WIDTH bits of S×T. rsp_ovf = any upper product bit set.
- 110 PUSH: push cmd_data. Error if full. rsp_data = cmd_data.
- 111 POP: remove T. Error if empty. rsp_data = popped T.
- SUB/ADD/MUL also error if depth<2.
- On any error: stack and depth unchanged, rsp_data=0, rsp_ovf=0.
- Arithmetic ops: net depth −1. rsp_data = result, which is the new T.
- FSM states:
  - IDLE: accept → EXEC, or → MUL for a valid MUL.
  - EXEC: commit, respond → IDLE.
  - MUL: WIDTH iterations → EXEC.

## Timing
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready.
- Non-MUL ops and erroring MUL: stack commits and rsp_valid asserts exactly 1 cycle after accept.
- Valid MUL: rsp_valid asserts WIDTH+1 cycles after accept. cmd_ready stays low throughout.
- No response backpressure. Max throughput: one command per 2 cycles.
- depth/empty/full update on the same edge that raises rsp_valid.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_ovf=0, depth=0, empty=1, full=0.
- Stack contents need not be cleared on reset.
- Reset mid-MUL aborts the operation: no response is produced and the stack is empty.

## Configuration
- STACK_CALC_SAT_EN defined: results saturate on overflow, and rsp_ovf still asserts.
  - ADD overflow → all ones.
  - SUB borrow → 0.
  - MUL overflow → all ones.
- Undefined: results wrap modulo 2^WIDTH.

## Structure
- Package stack_calc_pkg holds:
  - op_e enum: NOP, DUP, SWAP, SUB, ADD, MUL, PUSH, POP.
  - state_e enum: IDLE, EXEC, MUL.
  - Constant PTR_W = $clog2(DEPTH)+1.
- Sub-module stack_calc_mul: iterative shift-add multiplier.
  - Ports: start, a, b, WIDTH-cycle busy, done, 2·WIDTH-bit product.
  - Instantiated once.
- Stack memory: register array indexed by depth-1 / depth-2. Full-depth and empty pointer states are encoded without wrap.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- PUSH 200, PUSH 100, ADD → rsp_data=44, rsp_ovf=1, depth=1. With SAT_EN: rsp_data=255.
- PUSH 3, PUSH 5, SUB → rsp_data=254, rsp_ovf=1. Then POP → rsp_data=254, empty=1.
- PUSH 20, PUSH 13, MUL → rsp_valid exactly 9 cycles after accept, cmd_ready=0 meanwhile, rsp_data=4, rsp_ovf=1.
- 4× PUSH then PUSH 9 → rsp_err=1, full=1, T unchanged. POP on empty → rsp_err=1, rsp_data=0.
- PUSH 1, PUSH 2, SWAP, DUP → rsp_data=1 for both, depth=3. ADD with depth=1 → rsp_err=1.
- Assert rst_n low 3 cycles into a MUL → no rsp_valid, depth=0, cmd_ready=1 after release.
